// File: rtl/digit_serial_adder_pkg.sv
// Shared constants for the digit-serial adder: FSM encodings, digit width and counter sizing.
package digit_serial_adder_pkg;

  localparam logic [1:0] DSA_IDLE = 2'd0;
  localparam logic [1:0] DSA_RUN  = 2'd1;
  localparam logic [1:0] DSA_DONE = 2'd2;

  localparam int DSA_DIGIT_W = 2;

  function automatic int dsa_cnt_w(input int digits);
    return $clog2(digits) + 1;
  endfunction

endpackage

// File: rtl/adder_2_structure.sv
// Two-bit ripple-carry adder slice, reused once per digit by the serial controller.
module adder_2_structure (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       out
);

  logic c1;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign out    = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder feeding one 2-bit slice per clock, LSB digit first.
// Define DSA_SUB_EN to add a 'sub' input selecting a - b (cout=1 means no borrow).
//
// state    | meaning
// DSA_IDLE | waiting for start; operands captured on accepted start
// DSA_RUN  | one digit per cycle through the slice, DIGITS cycles
// DSA_DONE | one-cycle done pulse; sum/cout just committed
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int DIGITS = WIDTH / DSA_DIGIT_W;
  localparam int CNT_W  = dsa_cnt_w(DIGITS);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       slice_b;
  logic [1:0]       slice_sum;
  logic             slice_out;
  logic             last_digit;
  logic             carry_init;
  logic [WIDTH+1:0] res_cat;
  logic [WIDTH-1:0] res_next;

`ifdef DSA_SUB_EN
  logic sub_q;

  // Subtraction is a + ~b + 1: invert each B digit and seed the carry with 1.
  assign slice_b    = b_sh[1:0] ^ {2{sub_q}};
  assign carry_init = sub ? 1'b1 : cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (state == DSA_IDLE && start) begin
      sub_q <= sub;
    end
  end
`else
  assign slice_b    = b_sh[1:0];
  assign carry_init = cin;
`endif

  adder_2_structure u_slice (
    .a   (a_sh[1:0]),
    .b   (slice_b),
    .cin (carry),
    .sum (slice_sum),
    .out (slice_out)
  );

  // Result digits enter at the MSB end so the first (LSB) digit ends up at bit 0.
  assign res_cat    = {slice_sum, res_sh};
  assign res_next   = res_cat[WIDTH+1:2];
  assign last_digit = (cnt == CNT_W'(DIGITS - 1));

  assign busy = (state == DSA_RUN);
  assign done = (state == DSA_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= DSA_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        DSA_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= carry_init;
            cnt   <= '0;
            state <= DSA_RUN;
          end
        end
        DSA_RUN: begin
          carry  <= slice_out;
          res_sh <= res_next;
          a_sh   <= a_sh >> DSA_DIGIT_W;
          b_sh   <= b_sh >> DSA_DIGIT_W;
          cnt    <= cnt + CNT_W'(1);
          if (last_digit) begin
            sum   <= res_next;
            cout  <= slice_out;
            state <= DSA_DONE;
          end
        end
        DSA_DONE: begin
          state <= DSA_IDLE;
        end
        default: begin
          state <= DSA_IDLE;
        end
      endcase
    end
  end

endmodule
